// File: rtl/alu_pkg.sv
// Shared ALU op encodings and controller state encodings.
// Also holds the rule for which ops may see the sub/sra select.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SR   = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Only add/sub and srl/sra interpret the select bit.
    function automatic logic sel_used(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SR);
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU shared by the requesters.
// Op 011 has no datapath here and produces a zero result.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    input  logic        sel,
    output logic [31:0] out,
    output logic        zero
);

    always_comb begin
        out = '0;
        case (op)
            OP_ADD: out = sel ? (a - b) : (a + b);
            OP_SLL: out = a << b;
            OP_SLT: out = {31'b0, ($signed(a) < $signed(b))};
            OP_XOR: out = a ^ b;
            OP_SR:  out = sel ? 32'($signed(a) >>> b) : (a >> b);
            OP_OR:  out = a | b;
            OP_AND: out = a & b;
            default: out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 (mod N)
// for the first request; gnt is one-hot and only asserted when en=1.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        sum    = '0;
        idx    = '0;
        found  = 1'b0;
        gnt_id = '0;
        gnt    = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(N)) begin
                sum = sum - (IDW+1)'(N);
            end
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        if (en && found) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between NREQ requesters with round-robin arbitration and a
// single registered, id-tagged response channel (1-cycle issue-to-response).
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter bit REJ_SLTU = 1'b1,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*3-1:0]    req_op,
    input  logic [NREQ-1:0]      req_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_out,
    output logic                 rsp_zero,
    output logic                 rsp_err
);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both 1. Requests hold valid/payload until ready; the response holds
    // rsp_* stable while rsp_valid=1 and rsp_ready=0.

    logic [0:0]      state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_id;
    logic [NREQ-1:0] gnt;
    logic            can_issue;
    logic            grant;

    logic [31:0] a_mux;
    logic [31:0] b_mux;
    logic [2:0]  op_mux;
    logic        sel_mux;
    logic        alu_sel;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        rej;

    // A held response must be handed off in the same cycle before a new one may issue.
    assign can_issue = (state == ST_IDLE) | rsp_ready;

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .en     (can_issue & ~rst),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;
    assign grant     = |gnt;

    always_comb begin
        a_mux   = '0;
        b_mux   = '0;
        op_mux  = '0;
        sel_mux = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                a_mux   = req_a[32*i +: 32];
                b_mux   = req_b[32*i +: 32];
                op_mux  = req_op[3*i +: 3];
                sel_mux = req_sel[i];
            end
        end
    end

    assign alu_sel = sel_mux & sel_used(op_mux);
    assign rej     = REJ_SLTU && (op_mux == OP_SLTU);

    alu u_alu (
        .a    (a_mux),
        .b    (b_mux),
        .op   (op_mux),
        .sel  (alu_sel),
        .out  (alu_out),
        .zero (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= IDW'(NREQ - 1);
            rsp_id   <= '0;
            rsp_out  <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            if (grant) begin
                state    <= ST_HOLD;
                ptr      <= gnt_id;
                rsp_id   <= gnt_id;
                rsp_out  <= rej ? 32'b0 : alu_out;
                rsp_zero <= rej | alu_zero;
                rsp_err  <= rej;
            end else if (rsp_ready) begin
                state <= ST_IDLE;
            end
        end
    end

    assign rsp_valid = (state == ST_HOLD);

endmodule
